// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage registers: state encoding and default widths.
package pipe_pkg;

    // Occupancy of a two-entry stage register (main + skid).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_CNT_WIDTH  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_INC,
    input  logic             i_CLR,
    output logic [WIDTH-1:0] o_CNT
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count: clear wins over increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_CLR) begin
            cnt_d = '0;
        end else if (i_INC && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-high reset.
    always_ff @(posedge i_CLK) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (i_RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_CNT = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one skid entry,
// flush (bubble injection) and a saturating stall-cycle counter.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_FLUSH,
    input  logic                  i_CNT_CLR,
    input  logic                  i_VALID,
    output logic                  o_READY,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic                  o_VALID,
    input  logic                  i_READY,
    output logic [DATA_WIDTH-1:0] o_DATA,
    output logic [CNT_WIDTH-1:0]  o_STALL_CNT
);

    logic [1:0]            state_d, state_q;
    logic [DATA_WIDTH-1:0] main_d,  main_q;
    logic [DATA_WIDTH-1:0] skid_d,  skid_q;
    logic                  in_fire;
    logic                  out_fire;

    // Handshake outputs come straight from the state register, so neither
    // i_VALID nor i_READY has a combinational path to any output.
    assign o_VALID  = (state_q != ST_EMPTY);
    assign o_READY  = (state_q != ST_SKID);
    assign o_DATA   = main_q;

    assign in_fire  = i_VALID & o_READY;
    assign out_fire = o_VALID & i_READY;

    // Next-state and entry updates; flush overrides every handshake transition.
    always_comb begin
        // NOTE: default every output first so no path leaves a value unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (i_FLUSH) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = i_DATA;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = i_DATA;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                        skid_d  = i_DATA;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // Older entry leaves first; the skid entry moves up behind it.
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers; reset overrides flush and any transfer.
    always_ff @(posedge i_CLK) begin
        // NOTE: the payload registers are reset too, so o_DATA reads zero after reset.
        if (i_RST) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Count cycles where downstream back-pressures a valid payload; flush does not touch it.
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .i_INC (o_VALID & ~i_READY),
        .i_CLR (i_CNT_CLR),
        .o_CNT (o_STALL_CNT)
    );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed vector table, hand
// sequences for reset, saturation and flush, and a random scoreboard run.
module tb_pipe_stage_skid_reg;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          cnt_clr;
    logic          in_valid;
    logic          out_ready_dut;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          ds_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_FLUSH     (flush),
        .i_CNT_CLR   (cnt_clr),
        .i_VALID     (in_valid),
        .o_READY     (out_ready_dut),
        .i_DATA      (in_data),
        .o_VALID     (out_valid),
        .i_READY     (ds_ready),
        .o_DATA      (out_data),
        .o_STALL_CNT (stall_cnt)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          fl;
        logic          clr;
        logic          ev;
        logic          er;
        logic          chkd;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r,
                         input logic fl, input logic clr);
        in_valid = v;
        in_data  = d;
        ds_ready = r;
        flush    = fl;
        cnt_clr  = clr;
    endtask

    // One clock edge, then sample outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [DW-1:0] d, input logic r, input logic fl,
                       input logic clr, input logic ev, input logic er, input logic chkd,
                       input logic [DW-1:0] ed, input logic [CW-1:0] ec);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.fl = fl; x.clr = clr;
        x.ev = ev; x.er = er; x.chkd = chkd; x.ed = ed; x.ec = ec;
        vecs.push_back(x);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] held;
        logic          was_stalled;
        logic          v, r, inf, outf;
        logic [DW-1:0] d;

        //   v  d      r  fl clr   ev er chkd ed      ec
        add(1, 16'h01, 1, 0, 0,    1, 1, 1, 16'h01, 0);  // stream
        add(1, 16'h02, 1, 0, 0,    1, 1, 1, 16'h02, 0);
        add(1, 16'h03, 1, 0, 0,    1, 1, 1, 16'h03, 0);
        add(0, 16'h00, 1, 0, 0,    0, 1, 0, 16'h00, 0);  // drain
        add(1, 16'h10, 0, 0, 0,    1, 1, 1, 16'h10, 0);  // fill main
        add(1, 16'h11, 0, 0, 0,    1, 0, 1, 16'h10, 1);  // fill skid
        add(1, 16'h12, 0, 0, 0,    1, 0, 1, 16'h10, 2);  // not accepted
        add(0, 16'h00, 1, 0, 0,    1, 1, 1, 16'h11, 2);  // 0x10 leaves
        add(0, 16'h00, 1, 0, 0,    0, 1, 0, 16'h00, 2);  // 0x11 leaves
        add(1, 16'h20, 0, 0, 0,    1, 1, 1, 16'h20, 2);
        add(1, 16'h21, 0, 0, 0,    1, 0, 1, 16'h20, 3);  // SKID
        add(1, 16'h55, 0, 1, 0,    0, 1, 1, 16'h00, 4);  // flush in SKID, 0x55 dropped
        add(0, 16'h00, 1, 0, 0,    0, 1, 1, 16'h00, 4);
        add(1, 16'h30, 1, 0, 0,    1, 1, 1, 16'h30, 4);
        add(1, 16'h31, 1, 1, 0,    0, 1, 1, 16'h00, 4);  // flush in FULL with in_fire
        add(0, 16'h00, 1, 0, 1,    0, 1, 1, 16'h00, 0);  // counter clear

        // Reset while upstream offers 0xAA.
        drive(1, 16'hAA, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        drive(0, 16'h00, 1, 0, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", out_ready_dut, 1);
        check("rst_data", out_data, 0);
        check("rst_cnt", stall_cnt, 0);
        step();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_data", out_data, 0);

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].fl, vecs[i].clr);
            step();
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
            check($sformatf("vec%0d_ready", i), out_ready_dut, vecs[i].er);
            if (vecs[i].chkd) check($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
            check($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].ec);
        end

        // Saturation: one entry held for 20 stalled cycles.
        drive(1, 16'h40, 0, 0, 0);
        step();
        drive(0, 16'h00, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("sat_hold_data", out_data, 16'h40);
        end
        check("sat_cnt", stall_cnt, 4'hF);
        drive(0, 16'h00, 0, 0, 1);
        step();
        check("clr_cnt", stall_cnt, 0);
        drive(0, 16'h00, 0, 0, 0);
        step();
        step();
        step();
        check("restall_cnt", stall_cnt, 3);
        drive(0, 16'h00, 1, 1, 0);
        step();
        check("flush_cnt_kept", stall_cnt, 3);
        check("flush_valid", out_valid, 0);
        drive(0, 16'h00, 1, 0, 0);
        step();
        check("idle_cnt_kept", stall_cnt, 3);

        // Reset mid-transfer overrides flush and counter clear alike.
        drive(1, 16'h66, 0, 0, 0);
        step();
        step();
        check("pre_rst_cnt", stall_cnt, 4);
        drive(1, 16'h77, 0, 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 16'h00, 1, 0, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", out_ready_dut, 1);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_cnt", stall_cnt, 0);

        // Random handshake with a FIFO scoreboard; the queue depth is the model state.
        was_stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_valid", out_valid, q.size() > 0);
            check("rnd_ready", out_ready_dut, q.size() < 2);
            if (q.size() > 0) check("rnd_data", out_data, q[0]);
            if (was_stalled) check("rnd_stable", out_data, held);
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = DW'($urandom);
            inf  = v && (q.size() < 2);
            outf = r && (q.size() > 0);
            was_stalled = (q.size() > 0) && !r;
            held = (q.size() > 0) ? q[0] : '0;
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(d);
            drive(v, d, r, 0, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
